// File: rtl/mux4_sched_pkg.sv
// Shared definitions for the 4-source round-robin mux scheduler.
//   NUM_REQ   : number of requesters sharing the mux
//   SEL_W     : width of a source index / mux select
//   req_vec_t : per-source request / grant vector
//   next_idx  : index of the following source, wrapping 3 -> 0
package mux4_sched_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  typedef logic [NUM_REQ-1:0] req_vec_t;

  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
    // Two-bit addition wraps naturally from 3 back to 0.
    return idx + SEL_W'(1);
  endfunction

endpackage

// File: rtl/mux4_rr_pick.sv
// Combinational rotating priority encoder.
//   req : per-source request vector
//   ptr : index holding top priority this cycle
//   w   : first requesting index scanning ptr, ptr+1, ... (ptr when none request)
//   any : at least one source is requesting
module mux4_rr_pick
  import mux4_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   w,
  output logic               any
);

  logic             found;
  logic [SEL_W-1:0] idx;

  always_comb begin
    w     = ptr;
    found = 1'b0;
    idx   = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[idx]) begin
        w     = idx;
        found = 1'b1;
      end
      idx = next_idx(idx);
    end
    any = found;
  end

endmodule

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler driving the select of a shared 4:1 datapath mux.
// Picks one requesting source per cycle, steers its data to dout and hands
// it off with a valid/ready handshake. A stalled winner is locked until
// its transfer completes.
// Optional feature: define MUX4_SCHED_BURST_EN to let a winner keep top
// priority for up to BURST_LEN consecutive transfers.
//   clk, rst_n : clock, asynchronous active-low reset
//   req, din   : per-source valid and packed data (slice i = din[i*WIDTH +: WIDTH])
//   out_ready  : downstream accepts dout
//   gnt        : one-hot acknowledge of the consumed source
//   sel, dout  : mux select and selected data
//   out_valid  : dout holds valid data
module mux4_rr_sched
  import mux4_sched_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] din,
  input  logic                     out_ready,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [SEL_W-1:0]         sel,
  output logic [WIDTH-1:0]         dout,
  output logic                     out_valid
);

  if (BURST_LEN < 1 || BURST_LEN > 15) begin : g_burst_len_check
    $error("mux4_rr_sched: BURST_LEN must be within 1..15");
  end

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             lock_q, lock_d;
  logic [SEL_W-1:0] lock_sel_q, lock_sel_d;
  logic [SEL_W-1:0] win;
  logic             any;
  logic [SEL_W-1:0] sel_raw;
  logic             valid_raw;
  req_vec_t         req_v;

`ifdef MUX4_SCHED_BURST_EN
  logic [3:0] bcnt_q, bcnt_d;
  logic [3:0] run_cnt;
`endif

  assign req_v = req;

  mux4_rr_pick u_pick (
    .req (req_v),
    .ptr (ptr_q),
    .w   (win),
    .any (any)
  );

  // While locked, only the held source matters; everything else waits.
  always_comb begin
    sel_raw   = lock_q ? lock_sel_q : win;
    valid_raw = lock_q ? req_v[lock_sel_q] : any;
  end

  always_comb begin
    ptr_d      = ptr_q;
    lock_d     = lock_q;
    lock_sel_d = lock_sel_q;
`ifdef MUX4_SCHED_BURST_EN
    bcnt_d     = bcnt_q;
    // A nonzero count implies ptr_q still names the previous winner, so a
    // different winner starts its own run from zero.
    run_cnt    = (sel_raw == ptr_q) ? bcnt_q : 4'd0;
`endif
    if (valid_raw && !out_ready) begin
      lock_d     = 1'b1;
      lock_sel_d = sel_raw;
    end else if (valid_raw && out_ready) begin
      lock_d = 1'b0;
`ifdef MUX4_SCHED_BURST_EN
      if (run_cnt < 4'(BURST_LEN - 1)) begin
        ptr_d  = sel_raw;
        bcnt_d = run_cnt + 4'd1;
      end else begin
        ptr_d  = next_idx(sel_raw);
        bcnt_d = 4'd0;
      end
`else
      ptr_d  = next_idx(sel_raw);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_sel_q <= '0;
`ifdef MUX4_SCHED_BURST_EN
      bcnt_q     <= 4'd0;
`endif
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
`ifdef MUX4_SCHED_BURST_EN
      bcnt_q     <= bcnt_d;
`endif
    end
  end

  // Outputs are forced quiet for as long as reset is held.
  always_comb begin
    out_valid = rst_n & valid_raw;
    sel       = rst_n ? sel_raw : '0;
    gnt       = '0;
    if (out_valid && out_ready) begin
      gnt[sel] = 1'b1;
    end
    dout = out_valid ? din[sel*WIDTH +: WIDTH] : '0;
  end

endmodule

// File: tb/tb_mux4_rr_sched.sv
`timescale 1ns/1ps
module tb_mux4_rr_sched;

  localparam int W = 4;
`ifdef MUX4_SCHED_BURST_EN
  localparam int BL = 2;
`else
  localparam int BL = 1;
`endif

  logic         clk;
  logic         rst_n;
  logic [3:0]   req;
  logic [4*W-1:0] din;
  logic         out_ready;
  logic [3:0]   gnt;
  logic [1:0]   sel;
  logic [W-1:0] dout;
  logic         out_valid;

  int errors = 0;
  int checks = 0;

  mux4_rr_sched #(
    .WIDTH     (W),
    .BURST_LEN (BL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .din       (din),
    .out_ready (out_ready),
    .gnt       (gnt),
    .sel       (sel),
    .dout      (dout),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: priority index, held (stalled) source, and the
  // length of the current same-source run of transfers.
  int       m_prio = 0;
  int       m_hold = -1;
  int       m_run  = 0;
  int       m_last = 0;
  logic [3:0] m_last_gnt = 4'b0000;

  function automatic void m_eval(output logic ev, output int es);
    if (m_hold >= 0) begin
      es = m_hold;
      ev = req[m_hold];
    end else begin
      es = m_prio;
      ev = 1'b0;
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (m_prio + k) % 4;
        if (!ev && req[j]) begin
          es = j;
          ev = 1'b1;
        end
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic ev;
    int   es;
    int   run;
    if (!rst_n) begin
      m_prio <= 0;
      m_hold <= -1;
      m_run  <= 0;
      m_last <= 0;
    end else begin
      m_eval(ev, es);
      if (ev && out_ready) begin
        m_hold <= -1;
        run = (m_run > 0 && es == m_last) ? m_run + 1 : 1;
        m_last <= es;
        if (run < BL) begin
          m_prio <= es;
          m_run  <= run;
        end else begin
          m_prio <= (es + 1) % 4;
          m_run  <= 0;
        end
      end else if (ev) begin
        m_hold <= es;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic       ev;
    int         es;
    logic [3:0] eg;
    logic [W-1:0] ed;
    m_eval(ev, es);
    if (!rst_n) begin
      ev = 1'b0;
      es = 0;
    end
    eg = (ev && out_ready) ? 4'(1 << es) : 4'b0000;
    ed = ev ? din[es*W +: W] : '0;
    chk("m_out_valid", 32'(out_valid), 32'(ev));
    chk("m_sel", 32'(sel), 32'(es));
    chk("m_gnt", 32'(gnt), 32'(eg));
    chk("m_dout", 32'(dout), 32'(ed));
    m_last_gnt = eg;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = 4'b1111;
    din       = 16'h4321;
    out_ready = 1'b1;

    // Reset holds outputs quiet even with every source requesting.
    step();
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);

    step();
    rst_n = 1'b1;
    #2;
    chk("rr_gnt0", 32'(gnt), 32'h1);
    step(); #2; chk("rr_gnt1", 32'(gnt), 32'h2);
    step(); #2; chk("rr_gnt2", 32'(gnt), 32'h4);
    step(); #2; chk("rr_gnt3", 32'(gnt), 32'h8);
    step(); #2; chk("rr_gnt4", 32'(gnt), 32'h1);

    // Single requester on slice 2.
    step();
    req = 4'b0100;
    din = 16'h5A37;
    #2;
    chk("one_valid", 32'(out_valid), 32'd1);
    chk("one_sel", 32'(sel), 32'd2);
    chk("one_dout", 32'(dout), 32'hA);
    chk("one_gnt", 32'(gnt), 32'h4);

    // Priority now at 3: wrap to 0 next.
    step();
    req = 4'b1001;
    #2; chk("wrap_gnt3", 32'(gnt), 32'h8);
    step(); #2; chk("wrap_gnt0", 32'(gnt), 32'h1);

    // Stall with source 1 toggling; grant must stay on source 0.
    step();
    rst_n = 1'b0;
    req   = 4'b0000;
    step();
    rst_n     = 1'b1;
    req       = 4'b0011;
    out_ready = 1'b0;
    #2;
    chk("stall_sel0", 32'(sel), 32'd0);
    chk("stall_gnt0", 32'(gnt), 32'd0);
    for (int c = 1; c < 3; c++) begin
      step();
      req[1] = ~req[1];
      #2;
      chk("stall_sel", 32'(sel), 32'd0);
      chk("stall_gnt", 32'(gnt), 32'd0);
    end
    step();
    out_ready = 1'b1;
    req       = 4'b0011;
    #2; chk("stall_release", 32'(gnt), 32'h1);
    step(); #2; chk("stall_next", 32'(gnt), 32'h2);

    // Reset asserted while locked on source 2.
    step();
    rst_n = 1'b0;
    step();
    rst_n     = 1'b1;
    req       = 4'b0100;
    out_ready = 1'b0;
    step();
    req = 4'b0101;
    #2;
    chk("lock_sel2", 32'(sel), 32'd2);
    chk("lock_gnt", 32'(gnt), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("lockrst_valid", 32'(out_valid), 32'd0);
    chk("lockrst_sel", 32'(sel), 32'd0);
    chk("lockrst_dout", 32'(dout), 32'd0);
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #2; chk("lockrst_first", 32'(gnt), 32'h1);

`ifdef MUX4_SCHED_BURST_EN
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req   = 4'b0011;
    #2; chk("burst0", 32'(gnt), 32'h1);
    step(); #2; chk("burst1", 32'(gnt), 32'h1);
    step(); #2; chk("burst2", 32'(gnt), 32'h2);
    step(); #2; chk("burst3", 32'(gnt), 32'h2);
    step(); #2; chk("burst4", 32'(gnt), 32'h1);
    step(); #2; chk("burst5", 32'(gnt), 32'h1);
`endif

    // Random protocol-obeying traffic with occasional resets.
    step();
    rst_n = 1'b0;
    req   = 4'b0000;
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 800; c++) begin
      step();
      rst_n     = ($urandom % 150 != 0);
      out_ready = ($urandom % 4 != 0);
      for (int i = 0; i < 4; i++) begin
        if (!req[i] || m_last_gnt[i]) begin
          req[i] = ($urandom % 3 == 0);
          din[i*W +: W] = W'($urandom);
        end
      end
    end

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux4_rr_sched.md
# mux4_rr_sched

Round-robin scheduler that shares one 4:1 datapath mux among four requesters and drives its select. Each cycle it picks one requesting source, steers that source's data to a single output, and completes transfers with a valid/ready handshake toward the downstream consumer. It sits between the four producer ports and the shared mux output stage.

## Interface
- WIDTH, 4, data width of each source and of the output
- BURST_LEN, 4, consecutive transfers a winner may keep priority for; used only with MUX4_SCHED_BURST_EN, legal range 1..15
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous assert, active-low
- req  input  4  per-source valid; bit i set means din slice i holds data
- din  input  4*WIDTH  source data; slice i is din[i*WIDTH +: WIDTH]
- out_ready  input  1  downstream accepts dout this cycle
- gnt  output  4  one-hot transfer acknowledge; gnt[i] high means slice i was consumed this cycle
- sel  output  2  mux select (index of the current winner)
- dout  output  WIDTH  selected data, equal to din slice sel
- out_valid  output  1  dout is valid

## Operation
- Registered state: ptr (2 bits, highest-priority index), lock (1 bit), lock_sel (2 bits), bcnt (4 bits, burst mode only).
- Unlocked: winner w is the first set bit of req, scanning ptr, ptr+1, ... with wrap 3->0. out_valid = |req, sel = w. If req == 0, then sel = ptr.
- Locked: sel = lock_sel, out_valid = req[lock_sel]. Other requests are ignored.
- dout = din slice sel at all times when out_valid is 1, and 0 otherwise.
- Transfer occurs when out_valid & out_ready. gnt[sel] = 1 in that cycle; all other gnt bits are 0.
- Stall (out_valid & !out_ready): lock <= 1, lock_sel <= sel. The grant cannot move while downstream is stalled.
- On a transfer: lock <= 0, ptr <= sel+1 mod 4 (without the burst feature).
- Sources obey valid/ready: once req[i] is high, it stays high with stable data until gnt[i]. After gnt[i], req[i] in the next cycle refers to new data.
- Starvation bound: a continuously requesting source is served within 4 transfers (within 4*BURST_LEN transfers in burst mode).

## Timing
- req to out_valid/sel/dout and out_ready to gnt are combinational, giving zero-cycle latency. Back-to-back transfers are possible every cycle with no bubble.
- State updates on the rising edge of clk.
- Reset values: ptr=0, lock=0, lock_sel=0, bcnt=0. While rst_n is low, out_valid, gnt, sel and dout are all forced to 0.
- Reset asserted mid-stall: the lock is dropped. After release, arbitration restarts from index 0.
- Simultaneous requests from all sources with out_ready held high: grants proceed 0,1,2,3,0,...
- Requests arriving while locked are held off, with no grant, until the locked transfer completes.

## Configuration
- MUX4_SCHED_BURST_EN defined:
  - On a transfer where bcnt < BURST_LEN-1: ptr <= sel, bcnt <= bcnt+1, so the same source keeps top priority.
  - Otherwise: ptr <= sel+1, bcnt <= 0.
  - bcnt also clears when the winner differs from the previous winner.
- Macro undefined: bcnt does not exist, and every transfer rotates ptr. Behaviour is then identical to BURST_LEN=1.

## Structure
- Package mux4_sched_pkg holds:
  - NUM_REQ=4 and SEL_W=2
  - the typedef for the req/gnt vector
  - the function computing next index with wrap
- Sub-module mux4_rr_pick: a combinational rotating priority encoder with inputs req and ptr, and outputs w and any. It is instantiated once.

## Test plan
- Reset with req=4'b1111: out_valid=0, gnt=0, sel=0. After release with out_ready=1, gnt sequence is 0001, 0010, 0100, 1000, 0001.
- req=4'b0100 with din slice 2 = 4'hA, out_ready=1: out_valid=1, sel=2, dout=4'hA, gnt=4'b0100 in the same cycle. Next ptr=3.
- Stall: req=4'b0011, ptr=0, out_ready=0 for 3 cycles while req[1] toggles. sel stays 0 and gnt stays 0 throughout. When out_ready rises, gnt=4'b0001, and the next grant goes to source 1.
- Wrap: ptr=3 and req=4'b1001. The first grant goes to source 3, then source 0.
- Burst (macro on, BURST_LEN=2), req=4'b0011 held: grant order is 0,0,1,1,0,0.
- rst_n pulsed low while locked on sel=2: outputs go to 0 immediately. After release, the first grant is the lowest set req bit starting from index 0.
